// File: rtl/wam_key.sv
// Input conditioning for the whack-a-mole panel: synchronises and debounces the
// eight mole switches and three buttons, producing tap/press pulses, lft/rgt auto-repeat and the pause flag.
module wam_key #(
  parameter int unsigned DB_CNT  = 4,
  parameter int unsigned REP_DLY = 12,
  parameter int unsigned REP_PER = 4
) (
  input  logic       clk,
  input  logic       clr_n,
  input  logic       tick,
  input  logic [7:0] sw,
  input  logic       lft,
  input  logic       rgt,
  input  logic       pse,
  output logic [7:0] sw_db,
  output logic [7:0] tap,
  output logic       lft_p,
  output logic       rgt_p,
  output logic       pse_flg,
  output logic       rdy
);

  typedef enum logic [1:0] {ST_IDLE, ST_HOLD, ST_REPEAT} rep_state_t;

  localparam logic [3:0] DB_LAST  = 4'(DB_CNT - 1);
  localparam logic [7:0] DLY_LAST = 8'(REP_DLY - 1);
  localparam logic [7:0] PER_LAST = 8'(REP_PER - 1);

  // Bit map: [7:0] switches, [8] lft, [9] rgt, [10] pse.
  logic [10:0] raw;
  logic [10:0] sync1_q, sync2_q;
  logic [10:0] stab_q, stab_d;
  logic [3:0]  cnt_q [11];
  logic [3:0]  cnt_d [11];
  logic [10:0] rise, fall;

  rep_state_t  rep_q [2];
  rep_state_t  rep_d [2];
  logic [7:0]  rcnt_q [2];
  logic [7:0]  rcnt_d [2];
  logic [1:0]  rep_pulse;

  logic        rdy_d;
  logic [7:0]  tap_d;
  logic        lft_p_d, rgt_p_d, pse_flg_d;

  assign raw   = {pse, rgt, lft, sw};
  assign sw_db = stab_q[7:0];

  always_comb begin
    stab_d    = stab_q;
    rdy_d     = rdy;
    rise      = '0;
    fall      = '0;
    rep_pulse = '0;
    for (int unsigned i = 0; i < 11; i++) cnt_d[i] = cnt_q[i];
    for (int unsigned j = 0; j < 2; j++) begin
      rep_d[j]  = rep_q[j];
      rcnt_d[j] = rcnt_q[j];
    end

    if (tick) begin
      if (!rdy) begin
        // Priming adopts the current levels silently, so no edge flags are raised.
        stab_d = sync2_q;
        rdy_d  = 1'b1;
        for (int unsigned i = 0; i < 11; i++) cnt_d[i] = '0;
      end else begin
        for (int unsigned i = 0; i < 11; i++) begin
          if (sync2_q[i] == stab_q[i]) begin
            cnt_d[i] = '0;
          end else if (cnt_q[i] == DB_LAST) begin
            stab_d[i] = ~stab_q[i];
            cnt_d[i]  = '0;
            rise[i]   = ~stab_q[i];
            fall[i]   = stab_q[i];
          end else begin
            cnt_d[i] = cnt_q[i] + 4'd1;
          end
        end
      end
    end

    // A release wins over any repeat count maturing on the same tick.
    for (int unsigned j = 0; j < 2; j++) begin
      if (fall[8+j]) begin
        rep_d[j]  = ST_IDLE;
        rcnt_d[j] = '0;
      end else if (rise[8+j]) begin
        rep_d[j]  = ST_HOLD;
        rcnt_d[j] = '0;
      end else if (tick) begin
        unique case (rep_q[j])
          ST_HOLD: begin
            if (rcnt_q[j] == DLY_LAST) begin
              rep_pulse[j] = 1'b1;
              rep_d[j]     = ST_REPEAT;
              rcnt_d[j]    = '0;
            end else begin
              rcnt_d[j] = rcnt_q[j] + 8'd1;
            end
          end
          ST_REPEAT: begin
            if (rcnt_q[j] == PER_LAST) begin
              rep_pulse[j] = 1'b1;
              rcnt_d[j]    = '0;
            end else begin
              rcnt_d[j] = rcnt_q[j] + 8'd1;
            end
          end
          default: ;
        endcase
      end
    end

    tap_d     = rise[7:0] | fall[7:0];
    lft_p_d   = rise[8] | rep_pulse[0];
    rgt_p_d   = rise[9] | rep_pulse[1];
    pse_flg_d = pse_flg ^ rise[10];
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      stab_q  <= '0;
      for (int unsigned i = 0; i < 11; i++) cnt_q[i] <= '0;
      for (int unsigned j = 0; j < 2; j++) begin
        rep_q[j]  <= ST_IDLE;
        rcnt_q[j] <= '0;
      end
      tap     <= '0;
      lft_p   <= 1'b0;
      rgt_p   <= 1'b0;
      pse_flg <= 1'b0;
      rdy     <= 1'b0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      stab_q  <= stab_d;
      for (int unsigned i = 0; i < 11; i++) cnt_q[i] <= cnt_d[i];
      for (int unsigned j = 0; j < 2; j++) begin
        rep_q[j]  <= rep_d[j];
        rcnt_q[j] <= rcnt_d[j];
      end
      tap     <= tap_d;
      lft_p   <= lft_p_d;
      rgt_p   <= rgt_p_d;
      pse_flg <= pse_flg_d;
      rdy     <= rdy_d;
    end
  end

endmodule

// File: tb/tb_wam_key.sv
// Directed bench for wam_key: priming, switch debounce/tap, glitch rejection,
// lft auto-repeat timing, pause toggling and reset in the middle of a rgt hold.
module tb_wam_key;

  logic       clk = 1'b0;
  logic       clr_n = 1'b0;
  logic       tick = 1'b0;
  logic [7:0] sw = 8'h05;
  logic       lft = 1'b0, rgt = 1'b0, pse = 1'b0;
  logic [7:0] sw_db, tap;
  logic       lft_p, rgt_p, pse_flg, rdy;

  int         n_chk = 0;
  int         n_err = 0;
  int         cyc = 0;
  logic [7:0] tap_acc;
  int         lft_cnt, rgt_cnt;

  wam_key #(.DB_CNT(4), .REP_DLY(12), .REP_PER(4)) dut (
    .clk(clk), .clr_n(clr_n), .tick(tick), .sw(sw), .lft(lft), .rgt(rgt), .pse(pse),
    .sw_db(sw_db), .tap(tap), .lft_p(lft_p), .rgt_p(rgt_p), .pse_flg(pse_flg), .rdy(rdy)
  );

  always #5 clk = ~clk;

  // tick is high for every 4th rising edge.
  always @(negedge clk) begin
    cyc++;
    tick = (cyc % 4 == 0);
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    tap_acc |= tap;
    lft_cnt += int'(lft_p);
    rgt_cnt += int'(rgt_p);
  endtask

  task automatic to_tick();
    do step(); while (!tick);
  endtask

  task automatic ticks(input int n);
    repeat (n) to_tick();
  endtask

  task automatic clr_acc();
    tap_acc = '0;
    lft_cnt = 0;
    rgt_cnt = 0;
  endtask

  task automatic wait_rdy(input string tag);
    for (int i = 0; i < 12 && !rdy; i++) step();
    chk(tag, rdy, 1'b1);
  endtask

  // Drives a new switch word and checks the single tap pulse on the 4th tick
  // after the value has crossed the synchronizer.
  task automatic sw_change(input logic [7:0] v, input logic [7:0] exp_tap, input string tag);
    logic [7:0] pre;
    int k;
    pre = '0;
    k = 0;
    sw = v;
    step();
    step();
    while (k < 4) begin
      step();
      if (tick) k++;
      if (k < 4) pre |= tap;
    end
    chk({tag, "_early"}, pre, 8'h00);
    chk({tag, "_tap"}, tap, exp_tap);
    chk({tag, "_db"}, sw_db, v);
    step();
    chk({tag, "_tap_off"}, tap, 8'h00);
  endtask

  initial begin
    int k;
    int npk;
    int dbl;
    logic prev;
    int pk [8];
    int exp_pk [6];
    exp_pk = '{4, 16, 20, 24, 28, 32};
    clr_acc();

    // Reset with sw=05 held
    repeat (6) step();
    chk("rst_rdy", rdy, 1'b0);
    chk("rst_sw_db", sw_db, 8'h00);
    chk("rst_tap", tap, 8'h00);
    chk("rst_lft_p", lft_p, 1'b0);
    chk("rst_rgt_p", rgt_p, 1'b0);
    chk("rst_pse_flg", pse_flg, 1'b0);

    to_tick();
    clr_n = 1'b1;
    clr_acc();
    wait_rdy("prime_rdy");
    chk("prime_sw_db", sw_db, 8'h05);
    ticks(3);
    chk("prime_no_tap", tap_acc, 8'h00);

    // Single switch 3 rise, then a three-switch simultaneous change
    sw_change(8'h0D, 8'h08, "sw3");
    sw_change(8'h3C, 8'h31, "multi");

    // Glitch on sw[1] for three ticks
    clr_acc();
    sw = 8'h3E;
    step();
    step();
    k = 0;
    while (k < 3) begin
      step();
      if (tick) k++;
    end
    sw = 8'h3C;
    ticks(8);
    chk("glitch_tap", tap_acc, 8'h00);
    chk("glitch_db", sw_db, 8'h3C);

    // lft auto-repeat: pulses recorded by tick index after synchronization
    clr_acc();
    npk = 0;
    dbl = 0;
    prev = 1'b0;
    for (int i = 0; i < 8; i++) pk[i] = 0;
    lft = 1'b1;
    step();
    step();
    k = 0;
    for (int e = 0; e < 400 && k < 50; e++) begin
      step();
      if (tick) k++;
      if (lft_p) begin
        if (npk < 8) pk[npk] = k;
        npk++;
      end
      if (lft_p && prev) dbl++;
      prev = lft_p;
      if (tick && k == 30) lft = 1'b0;
    end
    chk("rep_count", npk, 6);
    for (int i = 0; i < 6; i++) chk($sformatf("rep_at%0d", i), pk[i], exp_pk[i]);
    chk("rep_width", dbl, 0);
    chk("rep_no_rgt", rgt_cnt, 0);

    // Pause toggling
    chk("pse_init", pse_flg, 1'b0);
    pse = 1'b1;
    ticks(8);
    chk("pse_press1", pse_flg, 1'b1);
    ticks(10);
    chk("pse_hold1", pse_flg, 1'b1);
    pse = 1'b0;
    ticks(8);
    chk("pse_rel1", pse_flg, 1'b1);
    pse = 1'b1;
    ticks(8);
    chk("pse_press2", pse_flg, 1'b0);
    pse = 1'b0;
    ticks(8);
    chk("pse_rel2", pse_flg, 1'b0);
    pse = 1'b1;
    ticks(8);
    pse = 1'b0;
    ticks(8);
    chk("pse_press3", pse_flg, 1'b1);

    // Reset during rgt HOLD, rgt kept pressed
    clr_acc();
    rgt = 1'b1;
    ticks(8);
    chk("rgt_first", rgt_cnt, 1);
    sw = 8'hA5;
    step();
    step();
    step();
    to_tick();
    clr_n = 1'b0;
    step();
    chk("mid_rdy", rdy, 1'b0);
    chk("mid_sw_db", sw_db, 8'h00);
    chk("mid_tap", tap, 8'h00);
    chk("mid_lft_p", lft_p, 1'b0);
    chk("mid_rgt_p", rgt_p, 1'b0);
    chk("mid_pse_flg", pse_flg, 1'b0);
    clr_n = 1'b1;
    clr_acc();
    wait_rdy("reprime_rdy");
    chk("reprime_sw_db", sw_db, 8'hA5);
    ticks(30);
    chk("reprime_no_tap", tap_acc, 8'h00);
    chk("held_rgt_silent", rgt_cnt, 0);
    rgt = 1'b0;
    ticks(8);
    rgt = 1'b1;
    ticks(8);
    chk("rgt_repress", rgt_cnt, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/wam_key.md
WAM_KEY -- requirements
Module: wam_key

Interface
REQ-001 Parameter DB_CNT, default 4: consecutive disagreeing tick samples needed to accept a new input level (legal 2..15).
REQ-002 Parameter REP_DLY, default 12: ticks lft/rgt must be held before the first auto-repeat pulse (legal 1..255).
REQ-003 Parameter REP_PER, default 4: ticks between subsequent auto-repeat pulses (legal 1..255).
REQ-004 clk  in  1  single system clock; all state changes on its rising edge.
REQ-005 clr_n  in  1  reset, synchronous, active-low.
REQ-006 tick  in  1  one-clk sample strobe from the clk_cnt divider; debounce and repeat counters advance only on tick=1.
REQ-007 sw  in  8  raw mole switches, asynchronous.
REQ-008 lft, rgt, pse  in  1 each  raw buttons, asynchronous, pressed=1.
REQ-009 sw_db  out  8  debounced switch levels.
REQ-010 tap  out  8  one-clk pulse per bit on any accepted change of that switch (either direction).
REQ-011 lft_p, rgt_p  out  1 each  one-clk press pulses, including auto-repeat pulses.
REQ-012 pse_flg  out  1  pause level, toggled by each accepted pse press.
REQ-013 rdy  out  1  high once the priming sample has been taken after reset.

Function
REQ-014 Every raw input passes through a 2-flop synchronizer; a raw change at edge n is visible to the debouncer from edge n+2.
REQ-015 Each of the 11 inputs has an independent debouncer: stable level S plus counter C (4 bits).
REQ-016 On a tick, synchronized value equal to S: C cleared to 0.
REQ-017 On a tick, value differing from S: C increments; on the tick where C would reach DB_CNT, S inverts and C clears, all in that edge.
REQ-018 Off-tick cycles: S and C hold, regardless of the input.
REQ-019 tap[i] is registered: high for exactly the one clk following the edge where switch i's S changes; never high for 2 consecutive clks.
REQ-020 lft_p/rgt_p: one-clk pulse after the edge where the button's S goes 0->1; a 1->0 change produces no pulse.
REQ-021 Auto-repeat per lft/rgt, 3 states: IDLE (S=0), HOLD (counting to REP_DLY), REPEAT (counting to REP_PER).
REQ-022 IDLE->HOLD on the accepted press, repeat counter cleared; HOLD: on the tick the counter reaches REP_DLY, pulse and ->REPEAT with the counter cleared.
REQ-023 REPEAT: pulse on every tick where the counter reaches REP_PER, counter cleared; any state -> IDLE in the edge S goes 0, with no pulse.
REQ-024 pse_flg inverts in the edge pse's S goes 0->1; release has no effect; no auto-repeat on pse.
REQ-025 Priming: the first tick after reset release loads every S directly from the synchronizer, clears C, sets rdy, and emits no tap/lft_p/rgt_p pulse and no pse_flg toggle.
REQ-026 Before rdy: tick processing is priming only; all pulse outputs are 0.
REQ-027 Simultaneous changes on several switches accepted on the same tick raise all the matching tap bits in the same clk.
REQ-028 An input that bounces back before DB_CNT ticks produces no S change and no pulse.

Reset
REQ-029 When clr_n=0 at an edge: synchronizers, all S, C, repeat counters and state (IDLE), sw_db, tap, lft_p, rgt_p, pse_flg and rdy are cleared to 0; reset overrides tick.
REQ-030 Reset mid-debounce or mid-repeat discards the partial count; no pulse is emitted in or after the reset edge until after re-priming.

Verification
REQ-031 Setup for all scenarios: DB_CNT=4, tick every 4th clk, sw=8'h05 held through reset. Expected: after priming, rdy=1, sw_db=8'h05, tap never asserted.
REQ-032 Flip sw[3] 0->1 and hold. Expected: tap=8'h08 for exactly one clk, on the 4th tick after synchronization; sw_db=8'h0D.
REQ-033 Flip sw[1] for 3 ticks, then restore. Expected: no tap, and sw_db unchanged.
REQ-034 Hold lft for 30 ticks, with REP_DLY=12 and REP_PER=4. Expected: lft_p pulses at debounce acceptance, then at +12 ticks, +16, +20, ...; no pulse after release.
REQ-035 Press pse twice, each with a clean release. Expected: pse_flg goes 0->1->0; holding pse never toggles it again.
REQ-036 Drop clr_n for one edge during the HOLD state of rgt, with rgt still pressed. Expected: all outputs 0; re-priming sets sw_db from the inputs; no rgt_p until rgt is released and pressed again.
